// File: rtl/shim_threshold_integrator_mc_if.sv
// Sample-core / interlock bundle for the shim threshold integrator.
// The master drives config and samples; the slave returns status and trip flags.
interface shim_threshold_integrator_mc_if #(
   parameter int unsigned NUM_CH   = 8,
   parameter int unsigned SAMPLE_W = 15
);
   logic                         enable;
   logic                         sticky;
   logic [4:0]                   chunk_shift;
   logic [SAMPLE_W-1:0]          threshold_average;
   logic [NUM_CH-1:0]            ch_enable;
   logic                         sample_valid;
   logic [NUM_CH*SAMPLE_W-1:0]   abs_sample_concat;
   logic                         running;
   logic                         window_full;
   logic [NUM_CH-1:0]            over_ch;
   logic                         over_thresh;
   logic                         err_config;

   modport master (
      output enable, sticky, chunk_shift, threshold_average, ch_enable,
             sample_valid, abs_sample_concat,
      input  running, window_full, over_ch, over_thresh, err_config
   );

   modport slave (
      input  enable, sticky, chunk_shift, threshold_average, ch_enable,
             sample_valid, abs_sample_concat,
      output running, window_full, over_ch, over_thresh, err_config
   );
endinterface

// File: rtl/shim_threshold_integrator_mc.sv
// Multi-channel rolling-window absolute-current integrator with threshold trip.
// Window = 2^CHUNKS_LOG2 chunks of 2^chunk_shift accepted samples per channel.
module shim_threshold_integrator_mc #(
   parameter int unsigned NUM_CH      = 8,
   parameter int unsigned SAMPLE_W    = 15,
   parameter int unsigned CHUNKS_LOG2 = 4,
   parameter int unsigned MAX_SHIFT   = 20
) (
   input logic                           clk,
   input logic                           reset,
   shim_threshold_integrator_mc_if.slave bus
);
   localparam int unsigned CHUNK_W = SAMPLE_W + MAX_SHIFT;
   localparam int unsigned TOT_W   = CHUNK_W + CHUNKS_LOG2;
   localparam int unsigned DEPTH   = 1 << CHUNKS_LOG2;
   localparam int unsigned PTR_W   = CHUNKS_LOG2;
   localparam int unsigned CNT_W   = MAX_SHIFT + 1;

   typedef enum logic [1:0] {S_IDLE, S_RUNNING, S_TRIPPED, S_ERROR} state_e;

   state_e state_q, state_d;

   logic [4:0]          shift_q, shift_d;
   logic [TOT_W-1:0]    limit_q, limit_d;
   logic [NUM_CH-1:0]   mask_q, mask_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [PTR_W-1:0]    ptr_q, ptr_d;
   logic [CHUNK_W-1:0]  acc_q   [NUM_CH];
   logic [CHUNK_W-1:0]  acc_d   [NUM_CH];
   logic [CHUNK_W-1:0]  ring_q  [NUM_CH][DEPTH];
   logic [CHUNK_W-1:0]  ring_d  [NUM_CH][DEPTH];
   logic [TOT_W-1:0]    total_q [NUM_CH];
   logic [TOT_W-1:0]    total_d [NUM_CH];
   logic                wfull_q, wfull_d;
   logic [NUM_CH-1:0]   over_ch_q, over_ch_d;
   logic                over_q, over_d;
   logic                err_q, err_d;
   logic                running_q;

   logic                cfg_bad_c;
   logic [CNT_W:0]      one_sh_c;
   logic [CNT_W-1:0]    cnt_last_c;
   logic                commit_c;
   logic [CHUNK_W-1:0]  new_c [NUM_CH];
   logic [NUM_CH-1:0]   hit_c;
   logic                start_c, step_c, stop_c, cmp_c, err_set_c;

   assign cfg_bad_c  = 32'(bus.chunk_shift) > MAX_SHIFT;
   assign one_sh_c   = (CNT_W+1)'(1) << shift_q;
   assign cnt_last_c = CNT_W'(one_sh_c - (CNT_W+1)'(1));
   assign commit_c   = (cnt_q == cnt_last_c);

   // Per-channel chunk candidate and committed-total compare
   always_comb begin
      hit_c = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         new_c[i] = acc_q[i] + CHUNK_W'(bus.abs_sample_concat[i*SAMPLE_W +: SAMPLE_W]);
         hit_c[i] = mask_q[i] & (total_q[i] > limit_q);
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // FSM next state; TRIPPED and ERROR are left only through reset
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (bus.enable) state_d = cfg_bad_c ? S_ERROR : S_RUNNING;
         end
         S_RUNNING: begin
            if (!bus.enable)                 state_d = S_IDLE;
            else if (bus.sticky && |hit_c)   state_d = S_TRIPPED;
         end
         S_TRIPPED: state_d = S_TRIPPED;
         S_ERROR:   state_d = S_ERROR;
         default:   state_d = S_IDLE;
      endcase
   end

   // FSM control decode
   always_comb begin
      start_c   = 1'b0;
      err_set_c = 1'b0;
      step_c    = 1'b0;
      stop_c    = 1'b0;
      cmp_c     = 1'b0;
      case (state_q)
         S_IDLE: begin
            start_c   = bus.enable & ~cfg_bad_c;
            err_set_c = bus.enable &  cfg_bad_c;
         end
         S_RUNNING: begin
            stop_c = ~bus.enable;
            cmp_c  =  bus.enable;
            step_c =  bus.enable & bus.sample_valid;
         end
         default: ;
      endcase
   end

   // Datapath and flag next-state
   always_comb begin
      shift_d   = shift_q;
      limit_d   = limit_q;
      mask_d    = mask_q;
      cnt_d     = cnt_q;
      ptr_d     = ptr_q;
      acc_d     = acc_q;
      ring_d    = ring_q;
      total_d   = total_q;
      wfull_d   = wfull_q;
      over_ch_d = over_ch_q;
      over_d    = over_q;
      err_d     = err_q | err_set_c;

      if (start_c) begin
         shift_d = bus.chunk_shift;
         mask_d  = bus.ch_enable;
         limit_d = TOT_W'(bus.threshold_average) << (32'(bus.chunk_shift) + CHUNKS_LOG2);
         cnt_d   = '0;
         ptr_d   = '0;
         wfull_d = 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            acc_d[i]   = '0;
            total_d[i] = '0;
            for (int j = 0; j < DEPTH; j++) ring_d[i][j] = '0;
         end
      end else if (step_c) begin
         if (commit_c) begin
            cnt_d = '0;
            ptr_d = ptr_q + PTR_W'(1);
            if (ptr_q == PTR_W'(DEPTH-1)) wfull_d = 1'b1;
            // Evicted chunk is always part of the total, so this never underflows
            for (int i = 0; i < NUM_CH; i++) begin
               acc_d[i]         = '0;
               ring_d[i][ptr_q] = new_c[i];
               total_d[i]       = total_q[i] + TOT_W'(new_c[i]) - TOT_W'(ring_q[i][ptr_q]);
            end
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
            for (int i = 0; i < NUM_CH; i++) acc_d[i] = new_c[i];
         end
      end else if (stop_c) begin
         wfull_d = 1'b0;
      end

      if (start_c || stop_c) begin
         over_ch_d = '0;
         over_d    = 1'b0;
      end else if (cmp_c) begin
         over_ch_d = hit_c;
         over_d    = |hit_c;
      end
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         shift_q   <= '0;
         limit_q   <= '0;
         mask_q    <= '0;
         cnt_q     <= '0;
         ptr_q     <= '0;
         wfull_q   <= 1'b0;
         over_ch_q <= '0;
         over_q    <= 1'b0;
         err_q     <= 1'b0;
         running_q <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            acc_q[i]   <= '0;
            total_q[i] <= '0;
            for (int j = 0; j < DEPTH; j++) ring_q[i][j] <= '0;
         end
      end else begin
         shift_q   <= shift_d;
         limit_q   <= limit_d;
         mask_q    <= mask_d;
         cnt_q     <= cnt_d;
         ptr_q     <= ptr_d;
         wfull_q   <= wfull_d;
         over_ch_q <= over_ch_d;
         over_q    <= over_d;
         err_q     <= err_d;
         running_q <= (state_d == S_RUNNING);
         acc_q     <= acc_d;
         total_q   <= total_d;
         ring_q    <= ring_d;
      end
   end

   assign bus.running     = running_q;
   assign bus.window_full = wfull_q;
   assign bus.over_ch     = over_ch_q;
   assign bus.over_thresh = over_q;
   assign bus.err_config  = err_q;
endmodule

// File: tb/tb_shim_threshold_integrator_mc.sv
// Directed bench for shim_threshold_integrator_mc: 2 channels, window of 4 chunks.
module tb_shim_threshold_integrator_mc;
   localparam int unsigned NCH = 2;
   localparam int unsigned SW  = 15;

   logic clk = 1'b0;
   logic reset;
   int   total_cnt = 0;
   int   bad_cnt   = 0;

   always #5 clk = ~clk;

   shim_threshold_integrator_mc_if #(.NUM_CH(NCH), .SAMPLE_W(SW)) bus ();

   shim_threshold_integrator_mc #(
      .NUM_CH(NCH), .SAMPLE_W(SW), .CHUNKS_LOG2(2), .MAX_SHIFT(4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total_cnt++;
      if (got !== exp) begin
         bad_cnt++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [SW-1:0] s0, input logic [SW-1:0] s1);
      bus.sample_valid      = v;
      bus.abs_sample_concat = {s1, s0};
      tick();
   endtask

   task automatic do_reset();
      reset            = 1'b1;
      bus.enable       = 1'b0;
      bus.sample_valid = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   task automatic start(input logic [4:0] sh, input logic [SW-1:0] thr,
                        input logic [NCH-1:0] m, input logic st);
      bus.chunk_shift       = sh;
      bus.threshold_average = thr;
      bus.ch_enable         = m;
      bus.sticky            = st;
      bus.enable            = 1'b1;
      tick();
   endtask

   // Valid every third cycle; flags checked after the full window
   task automatic gated(input logic [NCH-1:0] m, input logic [SW-1:0] thr,
                        input logic [SW-1:0] s0, input logic [SW-1:0] s1,
                        input logic [NCH-1:0] exp_ov);
      do_reset();
      start(5'd1, thr, m, 1'b0);
      for (int v = 1; v <= 8; v++) begin
         drive(1'b0, s0, s1);
         drive(1'b0, s0, s1);
         if (v == 8) chk("gate_wf_pre", bus.window_full, 0);
         drive(1'b1, s0, s1);
      end
      chk("gate_wf", bus.window_full, 1);
      drive(1'b0, s0, s1);
      chk("gate_ovch", bus.over_ch, exp_ov);
      chk("gate_ovr", bus.over_thresh, |exp_ov);
   endtask

   logic [15:0] evict_exp;

   initial begin
      reset                 = 1'b1;
      bus.enable            = 1'b0;
      bus.sticky            = 1'b0;
      bus.chunk_shift       = '0;
      bus.threshold_average = '0;
      bus.ch_enable         = '0;
      bus.sample_valid      = 1'b0;
      bus.abs_sample_concat = '0;
      tick();
      tick();
      reset = 1'b0;
      chk("rst_run", bus.running, 0);
      chk("rst_wf", bus.window_full, 0);
      chk("rst_ovch", bus.over_ch, 0);
      chk("rst_ovr", bus.over_thresh, 0);
      chk("rst_err", bus.err_config, 0);

      // Equality: total 800 against limit 800 never trips
      start(5'd1, 15'd100, 2'b11, 1'b1);
      chk("eq_run", bus.running, 1);
      for (int k = 1; k <= 16; k++) begin
         drive(1'b1, 15'd100, 15'd0);
         if (k == 7) chk("eq_wf7", bus.window_full, 0);
         if (k == 8) chk("eq_wf8", bus.window_full, 1);
         chk("eq_ovr", bus.over_thresh, 0);
      end
      drive(1'b0, 15'd0, 15'd0);
      chk("eq_ovr_end", bus.over_thresh, 0);
      chk("eq_run_end", bus.running, 1);

      // Sticky trip: 808 > 800, flagged one edge after the 8th sample
      do_reset();
      start(5'd1, 15'd100, 2'b11, 1'b1);
      for (int k = 1; k <= 8; k++) drive(1'b1, 15'd101, 15'd0);
      chk("trip_lat", bus.over_thresh, 0);
      drive(1'b0, 15'd0, 15'd0);
      chk("trip_ovr", bus.over_thresh, 1);
      chk("trip_ovch", bus.over_ch, 2'b01);
      chk("trip_run", bus.running, 0);
      for (int k = 0; k < 4; k++) drive(1'b1, 15'd500, 15'd500);
      bus.enable = 1'b0;
      tick();
      bus.enable = 1'b1;
      tick();
      chk("trip_hold_ovr", bus.over_thresh, 1);
      chk("trip_hold_ovch", bus.over_ch, 2'b01);
      chk("trip_hold_run", bus.running, 0);

      // Live eviction: limit 720; totals 800,800,600,... -> flag only after ticks 9,10
      do_reset();
      start(5'd1, 15'd90, 2'b11, 1'b0);
      evict_exp = 16'h0300;
      for (int k = 1; k <= 16; k++) begin
         drive(1'b1, (k <= 8) ? 15'd100 : 15'd0, 15'd0);
         chk("ev_ovch", bus.over_ch, {1'b0, evict_exp[k-1]});
         chk("ev_ovr", bus.over_thresh, evict_exp[k-1]);
      end
      chk("ev_run", bus.running, 1);

      // Masking and valid gating; ch1 window total 1600
      gated(2'b01, 15'd100, 15'd101, 15'd200, 2'b01);
      gated(2'b10, 15'd200, 15'd0,   15'd200, 2'b00);
      gated(2'b10, 15'd199, 15'd0,   15'd200, 2'b10);

      // Config error on chunk_shift beyond the legal maximum
      do_reset();
      start(5'd5, 15'd100, 2'b11, 1'b0);
      chk("cfg_err", bus.err_config, 1);
      chk("cfg_run", bus.running, 0);
      bus.enable = 1'b0;
      tick();
      chk("cfg_err_hold", bus.err_config, 1);
      do_reset();
      chk("cfg_err_rst", bus.err_config, 0);
      start(5'd4, 15'd100, 2'b11, 1'b0);
      chk("cfg_max_run", bus.running, 1);
      chk("cfg_max_err", bus.err_config, 0);

      // Reset mid-run must discard stale chunk data
      do_reset();
      start(5'd1, 15'd100, 2'b11, 1'b0);
      for (int k = 0; k < 5; k++) drive(1'b1, 15'd300, 15'd300);
      chk("mid_run", bus.running, 1);
      reset = 1'b1;
      tick();
      chk("mid_rst_run", bus.running, 0);
      chk("mid_rst_wf", bus.window_full, 0);
      chk("mid_rst_ovch", bus.over_ch, 0);
      chk("mid_rst_ovr", bus.over_thresh, 0);
      reset = 1'b0;
      bus.sample_valid = 1'b0;
      start(5'd1, 15'd100, 2'b11, 1'b0);
      for (int k = 0; k < 8; k++) drive(1'b1, 15'd100, 15'd100);
      chk("mid_wf", bus.window_full, 1);
      drive(1'b0, 15'd0, 15'd0);
      chk("mid_ovch", bus.over_ch, 2'b00);

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end
endmodule
